uart_tx_fifo: RTL and testbench

- Byte buffer that sits directly upstream of the UART transmitter.
- Accepts bytes from the CPU/bus side in single-cycle writes and queues them in a circular FIFO.
- Drains one byte at a time into the transmitter through its valid/ready handshake.
- Frees software from polling the transmitter for every character.
- Reports fill level, empty/full status and a sticky overrun flag.

---
 rtl/uart_tx_fifo_if.sv | 28 ++
 rtl/uart_tx_fifo.sv | 93 +++++++++
 tb/tb_uart_tx_fifo.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: write-side and transmitter-side handshake bundle.
// slave = the FIFO; master = bus writer plus transmitter.
interface uart_tx_fifo_if;
   logic       wr_en;
   logic [7:0] wr_data;
   logic       wr_ready;
   logic       tx_valid;
   logic [7:0] tx_data;
   logic       tx_ready;

   modport slave (
      input  wr_en,
      input  wr_data,
      output wr_ready,
      output tx_valid,
      output tx_data,
      input  tx_ready
   );

   modport master (
      output wr_en,
      output wr_data,
      input  wr_ready,
      input  tx_valid,
      input  tx_data,
      output tx_ready
   );
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: circular byte FIFO draining into a UART transmitter.
// Ports: clk, reset (sync, high), bus (write + tx handshake), flush,
//   clr_overrun, level/empty/full (queued count), busy, overrun (sticky).
module uart_tx_fifo #(
   parameter  int DEPTH = 16,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          reset,
   uart_tx_fifo_if.slave bus,
   input  logic          flush,
   input  logic          clr_overrun,
   output logic [AW:0]   level,
   output logic          empty,
   output logic          full,
   output logic          busy,
   output logic          overrun
);

   typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

   state_t        state_q;
   state_t        state_d;
   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic [7:0]    tx_data_q;
   logic          wr_acc;
   logic          wr_drop;
   logic          load;

   assign level        = count;
   assign empty        = (count == '0);
   assign full         = (count == (AW+1)'(DEPTH));
   assign bus.wr_ready = !full;
   assign bus.tx_valid = (state_q == SEND);
   assign bus.tx_data  = tx_data_q;
   assign busy         = (state_q != IDLE);

   // flush wins over a same-cycle write: neither stored nor counted as drop
   assign wr_acc  = bus.wr_en & !full & !flush;
   assign wr_drop = bus.wr_en & full & !flush;

   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (!empty && !flush) begin
               load    = 1'b1;
               state_d = SEND;
            end
         end
         SEND: begin
            if (bus.tx_ready) state_d = GAP;
         end
         GAP: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (wr_acc) mem[wr_ptr] <= bus.wr_data;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         tx_data_q <= '0;
         overrun   <= 1'b0;
      end else begin
         state_q <= state_d;
         if (load) tx_data_q <= mem[rd_ptr];
         if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
         end else begin
            if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
            if (load)   rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(wr_acc) - (AW+1)'(load);
         end
         // a dropped write outranks a same-cycle clear
         if (wr_drop)          overrun <= 1'b1;
         else if (clr_overrun) overrun <= 1'b0;
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: randomized + directed bench with queue reference model.
// Monitor compares DUT outputs against model state and expected-byte queue.
module tb_uart_tx_fifo;
   localparam int DEPTH = 16;
   localparam int LW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          reset;
   logic          flush;
   logic          clr_overrun;
   logic [LW-1:0] level;
   logic          empty;
   logic          full;
   logic          busy;
   logic          overrun;

   uart_tx_fifo_if bus();

   uart_tx_fifo #(.DEPTH(DEPTH)) dut (
      .clk         (clk),
      .reset       (reset),
      .bus         (bus.slave),
      .flush       (flush),
      .clr_overrun (clr_overrun),
      .level       (level),
      .empty       (empty),
      .full        (full),
      .busy        (busy),
      .overrun     (overrun)
   );

   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;

   // reference model: pending bytes, in-flight flag, gap flag, overrun
   logic [7:0] mq[$];
   logic [7:0] exp_q[$];
   logic [7:0] sent[$];
   bit         m_fly = 0;
   bit         m_gap = 0;
   bit         m_ovr = 0;

   // transmitter model controls
   int tx_delay = 5;
   bit tx_stall = 0;

   task automatic check(input string name, input int got, input int exp);
      n_total++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
                    name, got, exp, $time);
   endtask

   task automatic model_step();
      bit was_full;
      bit ld;
      if (reset) begin
         mq.delete();
         exp_q.delete();
         m_fly = 0;
         m_gap = 0;
         m_ovr = 0;
         return;
      end
      was_full = (mq.size() == DEPTH);
      ld = !m_fly && !m_gap && mq.size() != 0 && !flush;
      if (m_gap) m_gap = 0;
      else if (m_fly && bus.tx_ready) begin
         m_fly = 0;
         m_gap = 1;
      end
      if (ld) begin
         exp_q.push_back(mq.pop_front());
         m_fly = 1;
      end
      if (flush) mq.delete();
      else if (bus.wr_en) begin
         if (was_full) m_ovr = 1;
         else mq.push_back(bus.wr_data);
      end
      if (clr_overrun && !(bus.wr_en && was_full && !flush)) m_ovr = 0;
   endtask

   initial begin : model
      forever begin
         @(posedge clk);
         model_step();
      end
   end

   initial begin : transmitter
      int vcnt;
      vcnt = 0;
      bus.tx_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (reset || bus.tx_ready) begin
            bus.tx_ready = 1'b0;
            vcnt = 0;
         end else if (bus.tx_valid && !tx_stall) begin
            vcnt++;
            if (vcnt >= tx_delay) bus.tx_ready = 1'b1;
         end else vcnt = 0;
      end
   end

   initial begin : monitor
      logic       pv;
      logic [7:0] cur;
      pv  = 1'b0;
      cur = 8'h00;
      @(posedge clk);
      forever begin
         @(negedge clk);
         check("level", int'(level), mq.size());
         check("flags",
               int'({empty, full, bus.wr_ready, busy, overrun, bus.tx_valid}),
               int'({mq.size() == 0, mq.size() == DEPTH, mq.size() != DEPTH,
                     m_fly || m_gap, m_ovr, m_fly}));
         if (bus.tx_valid && !pv) begin
            check("valid_expected", int'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) cur = exp_q.pop_front();
            sent.push_back(bus.tx_data);
         end
         if (bus.tx_valid) check("tx_data", int'(bus.tx_data), int'(cur));
         pv = bus.tx_valid;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [7:0] d);
      bus.wr_en   = 1'b1;
      bus.wr_data = d;
      step();
      bus.wr_en   = 1'b0;
   endtask

   task automatic wait_idle(input int lim);
      int n;
      n = 0;
      while ((level != 0 || busy) && n < lim) begin
         step();
         n++;
      end
      check("drain_in_time", int'(level == 0 && !busy), 1);
   endtask

   initial begin : stim
      int base;
      int n;
      bit seen55;
      reset       = 1'b1;
      flush       = 1'b0;
      clr_overrun = 1'b0;
      bus.wr_en   = 1'b0;
      bus.wr_data = 8'h00;
      step();
      step();
      reset = 1'b0;
      check("rst_level", int'(level), 0);
      check("rst_txv", int'(bus.tx_valid), 0);
      check("rst_txd", int'(bus.tx_data), 0);

      // single byte latency
      tx_delay = 5;
      wr(8'h41);
      check("t1_level1", int'(level), 1);
      step();
      check("t1_txv", int'(bus.tx_valid), 1);
      check("t1_txd", int'(bus.tx_data), 8'h41);
      check("t1_level0", int'(level), 0);
      check("t1_busy", int'(busy), 1);
      wait_idle(100);

      // three bytes, slow transmitter
      tx_delay = 50;
      base = sent.size();
      wr(8'h48);
      wr(8'h69);
      wr(8'h0A);
      wait_idle(1000);
      check("t2_count", sent.size() - base, 3);
      if (sent.size() - base == 3) begin
         check("t2_b0", int'(sent[base]), 8'h48);
         check("t2_b1", int'(sent[base+1]), 8'h69);
         check("t2_b2", int'(sent[base+2]), 8'h0A);
      end

      // overflow
      tx_stall = 1;
      base = sent.size();
      for (int i = 0; i < 18; i++) wr(8'(i));
      check("t3_level", int'(level), 16);
      check("t3_full", int'(full), 1);
      check("t3_wr_ready", int'(bus.wr_ready), 0);
      check("t3_overrun", int'(overrun), 1);
      tx_stall = 0;
      tx_delay = 2;
      wait_idle(2000);
      check("t3_count", sent.size() - base, 17);
      if (sent.size() - base == 17)
         for (int i = 0; i < 17; i++)
            check("t3_order", int'(sent[base+i]), i);
      clr_overrun = 1'b1;
      step();
      clr_overrun = 1'b0;
      check("t3_clr", int'(overrun), 0);

      // pointer wrap
      tx_stall = 1;
      tx_delay = 4;
      base = sent.size();
      for (int i = 0; i < 17; i++) wr(8'(8'h80 + i));
      tx_stall = 0;
      n = 0;
      while (sent.size() - base < 11 && n < 500) begin
         step();
         n++;
      end
      tx_stall = 1;
      check("t4_drained", sent.size() - base, 11);
      for (int i = 17; i < 25; i++) wr(8'(8'h80 + i));
      check("t4_level14", int'(level), 14);
      tx_stall = 0;
      wait_idle(2000);
      check("t4_count", sent.size() - base, 25);
      if (sent.size() - base == 25)
         for (int i = 0; i < 25; i++)
            check("t4_order", int'(sent[base+i]), 8'h80 + i);

      // flush with coincident write
      tx_stall = 1;
      base = sent.size();
      for (int i = 0; i < 6; i++) wr(8'(8'hA0 + i));
      flush       = 1'b1;
      bus.wr_en   = 1'b1;
      bus.wr_data = 8'h55;
      step();
      flush     = 1'b0;
      bus.wr_en = 1'b0;
      check("t5_level", int'(level), 0);
      check("t5_overrun", int'(overrun), 0);
      check("t5_inflight", int'(bus.tx_valid), 1);
      tx_stall = 0;
      wait_idle(500);
      repeat (10) step();
      check("t5_count", sent.size() - base, 1);
      seen55 = 0;
      for (int i = base; i < sent.size(); i++)
         if (sent[i] == 8'h55) seen55 = 1;
      check("t5_no55", int'(seen55), 0);

      // reset mid-frame
      tx_stall = 1;
      for (int i = 0; i < 4; i++) wr(8'(8'hC0 + i));
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("t6_txv", int'(bus.tx_valid), 0);
      check("t6_level", int'(level), 0);
      check("t6_empty", int'(empty), 1);
      check("t6_busy", int'(busy), 0);
      tx_stall = 0;
      tx_delay = 3;
      base = sent.size();
      wr(8'h7E);
      wait_idle(200);
      check("t6_count", sent.size() - base, 1);
      if (sent.size() - base == 1)
         check("t6_byte", int'(sent[base]), 8'h7E);

      // randomized traffic
      for (int c = 0; c < 3000; c++) begin
         if (c % 200 == 0) begin
            tx_delay = $urandom_range(1, 6);
            tx_stall = ($urandom_range(0, 4) == 0);
         end
         bus.wr_en   = ($urandom_range(0, 99) < 45);
         bus.wr_data = 8'($urandom);
         flush       = ($urandom_range(0, 99) == 0);
         clr_overrun = ($urandom_range(0, 49) == 0);
         step();
      end
      bus.wr_en   = 1'b0;
      flush       = 1'b0;
      clr_overrun = 1'b0;
      tx_stall    = 0;
      wait_idle(5000);
      repeat (5) step();
      check("final_scoreboard_empty", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
